// File: rtl/pla_eval_sched_pkg.sv
// Shared types and constants for the PLA evaluator/scheduler.
// Holds the FSM state enum, vector/count widths and the response bundle.
package pla_eval_sched_pkg;

    localparam int VEC_W = 9;
    localparam int CNT_W = 10;
    localparam logic [VEC_W-1:0] SWEEP_LAST = 9'd511;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic             y;
        logic             src;
        logic [VEC_W-1:0] vec;
    } resp_t;

endpackage

// File: rtl/pla_fn9.sv
// Combinational 9-input PLA function; x8 is a don't-care input.
// Ports: x (9-bit vector, bit i = xi) -> y (function value).
module pla_fn9
    import pla_eval_sched_pkg::*;
(
    input  logic [VEC_W-1:0] x,
    output logic             y
);

    logic unused_x8;

    assign unused_x8 = x[8];

    assign y = ~x[0] & x[4] & x[5] & x[7]
             & ((x[3] & x[6])
             | (~x[3] & x[2] & (x[6] | ~x[1])));

endmodule

// File: rtl/pla_eval_sched.sv
// Two-requester round-robin front end for pla_fn9 plus a full 512-vector ON-set sweep.
// Ports: clk/rst_n, rq0_*/rq1_* valid-ready requests, resp_* held response, sweep_* control/status.
module pla_eval_sched
    import pla_eval_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rq0_valid,
    output logic             rq0_ready,
    input  logic [VEC_W-1:0] rq0_vec,
    input  logic             rq1_valid,
    output logic             rq1_ready,
    input  logic [VEC_W-1:0] rq1_vec,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_y,
    output logic             resp_src,
    output logic [VEC_W-1:0] resp_vec,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [CNT_W-1:0] sweep_count
);

    state_e           state_q;
    state_e           state_d;
    logic             last_q;
    logic [VEC_W-1:0] vcnt_q;
    logic [CNT_W-1:0] cnt_q;
    resp_t            resp_q;
    logic             resp_valid_q;

    logic             slot_free;
    logic             g0;
    logic             g1;
    logic             accept;
    logic             start;
    logic             fn_y;
    logic [VEC_W-1:0] req_vec;
    logic [VEC_W-1:0] fn_x;

    // A held response that is being consumed this cycle frees the slot.
    assign slot_free = !resp_valid_q || resp_ready;
    assign start     = (state_q == IDLE) && sweep_start;
    assign accept    = g0 | g1;
    assign req_vec   = g1 ? rq1_vec : rq0_vec;

    // The single function instance serves the sweep while sweeping.
    assign fn_x = (state_q == SWEEP) ? vcnt_q : req_vec;

    pla_fn9 u_fn (
        .x (fn_x),
        .y (fn_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sweep_start) state_d = SWEEP;
            SWEEP:   if (vcnt_q == SWEEP_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // last_q = 1 means requester 1 was granted last, so 0 wins a tie.
    always_comb begin
        g0         = 1'b0;
        g1         = 1'b0;
        sweep_busy = 1'b0;
        sweep_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!sweep_start && slot_free) begin
                    if (rq0_valid && rq1_valid) begin
                        g0 = last_q;
                        g1 = !last_q;
                    end else begin
                        g0 = rq0_valid;
                        g1 = rq1_valid;
                    end
                end
            end
            SWEEP:   sweep_busy = 1'b1;
            DONE:    sweep_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            last_q       <= 1'b1;
        end else if (accept) begin
            resp_q.y     <= fn_y;
            resp_q.src   <= g1;
            resp_q.vec   <= req_vec;
            resp_valid_q <= 1'b1;
            last_q       <= g1;
        end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt_q <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            vcnt_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == SWEEP) begin
            vcnt_q <= vcnt_q + VEC_W'(1);
            cnt_q  <= cnt_q + CNT_W'(fn_y);
        end
    end

    assign rq0_ready   = g0;
    assign rq1_ready   = g1;
    assign resp_valid  = resp_valid_q;
    assign resp_y      = resp_q.y;
    assign resp_src    = resp_q.src;
    assign resp_vec    = resp_q.vec;
    assign sweep_count = cnt_q;

endmodule

// File: tb/tb_pla_eval_sched.sv
// Self-checking bench for pla_eval_sched: directed scenarios plus
// randomized request traffic against a behavioural reference model.
module tb_pla_eval_sched;

    logic       clk;
    logic       rst_n;
    logic       rq0_valid;
    logic       rq0_ready;
    logic [8:0] rq0_vec;
    logic       rq1_valid;
    logic       rq1_ready;
    logic [8:0] rq1_vec;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_y;
    logic       resp_src;
    logic [8:0] resp_vec;
    logic       sweep_start;
    logic       sweep_busy;
    logic       sweep_done;
    logic [9:0] sweep_count;

    int n_chk;
    int n_pass;

    logic       m_valid;
    logic       m_y;
    logic       m_src;
    logic [8:0] m_vec;
    logic       m_last;

    pla_eval_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rq0_valid   (rq0_valid),
        .rq0_ready   (rq0_ready),
        .rq0_vec     (rq0_vec),
        .rq1_valid   (rq1_valid),
        .rq1_ready   (rq1_ready),
        .rq1_vec     (rq1_vec),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_y      (resp_y),
        .resp_src    (resp_src),
        .resp_vec    (resp_vec),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_count (sweep_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d",
                      tag, got, exp);
    endtask

    function automatic logic ref_y(input logic [8:0] v);
        logic on_core;
        logic sel;
        on_core = !v[0] && v[4] && v[5] && v[7];
        sel = (v[3] && v[6])
           || (!v[3] && v[2] && (v[6] || !v[1]));
        return on_core && sel;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_y     = 1'b0;
        m_src   = 1'b0;
        m_vec   = '0;
        m_last  = 1'b1;
    endtask

    task automatic idle_inputs();
        rq0_valid   = 1'b0;
        rq1_valid   = 1'b0;
        rq0_vec     = '0;
        rq1_vec     = '0;
        resp_ready  = 1'b0;
        sweep_start = 1'b0;
    endtask

    // One IDLE-state cycle: check held response, drive, check grants,
    // then advance the model across the coming clock edge.
    task automatic cycle(input logic v0, input logic [8:0] x0,
                         input logic v1, input logic [8:0] x1,
                         input logic rdy);
        logic free;
        logic e0;
        logic e1;
        @(negedge clk);
        chk("resp_valid", resp_valid, m_valid);
        if (m_valid) begin
            chk("resp_y", resp_y, m_y);
            chk("resp_src", resp_src, m_src);
            chk("resp_vec", resp_vec, m_vec);
        end
        rq0_valid  = v0;
        rq0_vec    = x0;
        rq1_valid  = v1;
        rq1_vec    = x1;
        resp_ready = rdy;
        #1;
        free = !m_valid || rdy;
        e0 = 1'b0;
        e1 = 1'b0;
        if (free) begin
            if (v0 && v1) begin
                e0 = m_last;
                e1 = !m_last;
            end else if (v0) begin
                e0 = 1'b1;
            end else if (v1) begin
                e1 = 1'b1;
            end
        end
        chk("rq0_ready", rq0_ready, e0);
        chk("rq1_ready", rq1_ready, e1);
        if (e0 || e1) begin
            m_valid = 1'b1;
            m_src   = e1;
            m_vec   = e1 ? x1 : x0;
            m_y     = ref_y(m_vec);
            m_last  = e1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic run_sweep();
        int busy_n;
        int bad_rdy;
        int done_at;
        logic seen;
        @(negedge clk);
        sweep_start = 1'b1;
        rq0_valid   = 1'b1;
        rq1_valid   = 1'b1;
        resp_ready  = 1'b1;
        #1;
        chk("start_rdy0", rq0_ready, 0);
        chk("start_rdy1", rq1_ready, 0);
        busy_n  = 0;
        bad_rdy = 0;
        done_at = -1;
        seen    = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            busy_n += int'(sweep_busy);
            if (rq0_ready || rq1_ready) bad_rdy++;
            if (sweep_done) begin
                seen      = 1'b1;
                done_at   = i;
                rq0_valid = 1'b0;
                rq1_valid = 1'b0;
            end
            sweep_start = (i == 100);
        end
        sweep_start = 1'b0;
        chk("sweep_done_seen", seen, 1);
        chk("sweep_done_cycle", done_at, 512);
        chk("sweep_busy_cycles", busy_n, 512);
        chk("sweep_rdy_leak", bad_rdy, 0);
        chk("sweep_count", sweep_count, 14);
        @(negedge clk);
        chk("done_one_shot", sweep_done, 0);
        chk("busy_after", sweep_busy, 0);
        chk("count_hold", sweep_count, 14);
        m_valid = 1'b0;
    endtask

    initial begin
        logic [8:0] held_vec;
        logic       held_y;
        logic       held_src;
        int         done_n;

        n_chk  = 0;
        n_pass = 0;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_y", resp_y, 0);
        chk("rst_resp_src", resp_src, 0);
        chk("rst_resp_vec", resp_vec, 0);
        chk("rst_busy", sweep_busy, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_count", sweep_count, 0);
        rst_n = 1'b1;

        cycle(1, 9'h0B0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("v_0b0", resp_valid, 1);
        chk("y_0b0", resp_y, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 9'h0F8, 0, 0, 0);
        chk("pre_0f8_valid", resp_valid, 0);
        cycle(0, 0, 0, 0, 0);
        chk("v_0f8", resp_valid, 1);
        chk("y_0f8", resp_y, 1);
        chk("src_0f8", resp_src, 0);

        held_vec = resp_vec;
        held_y   = resp_y;
        held_src = resp_src;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 9'($urandom), 1, 9'($urandom), 0);
            chk("stall_rdy0", rq0_ready, 0);
            chk("stall_rdy1", rq1_ready, 0);
            chk("stall_valid", resp_valid, 1);
            chk("stall_vec", resp_vec, held_vec);
            chk("stall_y", resp_y, held_y);
            chk("stall_src", resp_src, held_src);
        end

        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_drop_valid", resp_valid, 0);
        chk("rst_drop_vec", resp_vec, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            cycle(1, 9'($urandom), 1, 9'($urandom), 1);
            chk("tie_rdy0", rq0_ready, (i % 2) == 0);
            chk("tie_rdy1", rq1_ready, (i % 2) == 1);
        end

        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom), 9'($urandom),
                  1'($urandom), 9'($urandom),
                  1'($urandom));
        end
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        run_sweep();
        cycle(0, 0, 0, 0, 1);

        @(negedge clk);
        idle_inputs();
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        repeat (199) @(negedge clk);
        chk("abort_busy_pre", sweep_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", sweep_busy, 0);
        chk("abort_count", sweep_count, 0);
        chk("abort_done", sweep_done, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            done_n += int'(sweep_done);
        end
        chk("abort_no_done", done_n, 0);

        run_sweep();
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom), 9'($urandom),
                  1'($urandom), 9'($urandom),
                  1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
